// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and defaults for the multiply/divide unit.
package muldiv_pkg;

   localparam int WIDTH_DEF = 32;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MADDU = 3'd5;
   localparam logic [2:0] OP_MSUB  = 3'd6;
   localparam logic [2:0] OP_MSUBU = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV_PREP,
      DIV_ITER,
      DIV_FIX
   } state_t;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per step.
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   // rem_q < div_q always holds, so a set top bit of diff means a borrow
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, div_q};

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         div_q <= '0;
      end else if (start) begin
         cnt_q <= CW'(WIDTH - 1);
         quo_q <= dividend;
         rem_q <= '0;
         div_q <= divisor;
      end else if (step) begin
         if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
         if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign last      = (cnt_q == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with start/busy/done handshake and flush.
// Define MULDIV_ACC_EN to make op codes 4-7 accumulate into the forwarded hilo_i.
//
// state    | meaning
// IDLE     | waiting for start; done_o pulses here after completion
// MUL      | multiply latency countdown
// DIV_PREP | zero-divisor check, load operand magnitudes into divider
// DIV_ITER | one restoring divide step per cycle
// DIV_FIX  | quotient/remainder sign fixup
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int MUL_CYCLES = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     operand_a_i,
   input  logic [WIDTH-1:0]     operand_b_i,
   input  logic [2*WIDTH-1:0]   hilo_i,
   input  logic                 flush_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 div_by_zero_o
);

   localparam int MCW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   state_t state_q, state_d;

   logic               signed_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [MCW-1:0]     mul_cnt_q;

   logic               accept, load_ops, mul_dec;
   logic               div_start, div_step, div_last;
   logic               set_done, dbz_d;
   logic [2*WIDTH-1:0] result_d, result_q;
   logic               done_q, dbz_q;

   logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
   logic               a_neg, b_neg, q_neg, r_neg;
   logic [WIDTH-1:0]   mag_a, mag_b, quo, rem, quo_fix, rem_fix;

   assign accept = (state_q == IDLE) && start_i && !flush_i;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         signed_q  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         mul_cnt_q <= '0;
      end else if (load_ops) begin
         signed_q  <= ~op_i[0];
         a_q       <= operand_a_i;
         b_q       <= operand_b_i;
         mul_cnt_q <= MCW'(MUL_CYCLES - 1);
      end else if (mul_dec) begin
         mul_cnt_q <= mul_cnt_q - MCW'(1);
      end
   end

   // Operands are stable for the whole MUL state, so the multiplier is a
   // MUL_CYCLES-cycle path from the operand latches to result_q.
   assign ext_a   = {{WIDTH{signed_q & a_q[WIDTH-1]}}, a_q};
   assign ext_b   = {{WIDTH{signed_q & b_q[WIDTH-1]}}, b_q};
   assign product = ext_a * ext_b;

`ifdef MULDIV_ACC_EN
   logic               acc_q, sub_q;
   logic [2*WIDTH-1:0] hilo_q;

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         acc_q  <= 1'b0;
         sub_q  <= 1'b0;
         hilo_q <= '0;
      end else if (load_ops) begin
         acc_q  <= op_i[2];
         sub_q  <= op_i[1];
         hilo_q <= hilo_i;
      end
   end

   always_comb begin
      mul_result = product;
      if (acc_q) mul_result = sub_q ? (hilo_q - product) : (hilo_q + product);
   end
`else
   logic unused_hilo;
   assign unused_hilo = ^hilo_i;
   assign mul_result  = product;
`endif

   assign a_neg   = signed_q & a_q[WIDTH-1];
   assign b_neg   = signed_q & b_q[WIDTH-1];
   assign mag_a   = a_neg ? -a_q : a_q;
   assign mag_b   = b_neg ? -b_q : b_q;
   assign q_neg   = a_neg ^ b_neg;
   assign r_neg   = a_neg;
   assign quo_fix = q_neg ? -quo : quo;
   assign rem_fix = r_neg ? -rem : rem;

   muldiv_div_core #(
      .WIDTH (WIDTH)
   ) u_div_core (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .start     (div_start),
      .step      (div_step),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (quo),
      .remainder (rem),
      .last      (div_last)
   );

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load_ops  = 1'b0;
      mul_dec   = 1'b0;
      div_start = 1'b0;
      div_step  = 1'b0;
      set_done  = 1'b0;
      dbz_d     = 1'b0;
      result_d  = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load_ops = 1'b1;
               state_d  = is_div_op(op_i) ? DIV_PREP : MUL;
            end
         end
         MUL: begin
            if (mul_cnt_q == '0) begin
               state_d  = IDLE;
               set_done = 1'b1;
               result_d = mul_result;
            end else begin
               mul_dec = 1'b1;
            end
         end
         DIV_PREP: begin
            if (b_q == '0) begin
               state_d  = IDLE;
               set_done = 1'b1;
               dbz_d    = 1'b1;
               result_d = {a_q, {WIDTH{1'b1}}};
            end else begin
               div_start = 1'b1;
               state_d   = DIV_ITER;
            end
         end
         DIV_ITER: begin
            div_step = 1'b1;
            if (div_last) state_d = DIV_FIX;
         end
         DIV_FIX: begin
            state_d  = IDLE;
            set_done = 1'b1;
            result_d = {rem_fix, quo_fix};
         end
         default: state_d = IDLE;
      endcase
      // Flush beats everything, including a same-cycle start or completion.
      if (flush_i) begin
         state_d   = IDLE;
         load_ops  = 1'b0;
         mul_dec   = 1'b0;
         div_start = 1'b0;
         div_step  = 1'b0;
         set_done  = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= set_done;
         dbz_q  <= set_done & dbz_d;
         if (set_done) result_q <= result_d;
      end
   end

   assign busy_o        = (state_q != IDLE);
   assign done_o        = done_q;
   assign result_o      = result_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   localparam int WIDTH      = 32;
   localparam int MUL_CYCLES = 2;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] operand_a_i, operand_b_i;
   logic [63:0] hilo_i;
   logic        flush_i;
   logic        busy_o, done_o, div_by_zero_o;
   logic [63:0] result_o;

   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] last_res = '0;

   muldiv_unit #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .start_i       (start_i),
      .op_i          (op_i),
      .operand_a_i   (operand_a_i),
      .operand_b_i   (operand_b_i),
      .hilo_i        (hilo_i),
      .flush_i       (flush_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .result_o      (result_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // bit 64 = div_by_zero, bits 63:0 = {HI, LO}
   function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
      longint            sa, sb, q, r;
      longint unsigned   ua, ub, uq, ur;
      logic [63:0]       prod;
      logic [63:0]       res;
      bit                sgn;
      sgn = (op[0] == 1'b0);
      sa  = longint'(signed'(a));
      sb  = longint'(signed'(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      if (op == 3'd2 || op == 3'd3) begin
         if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
         if (sgn) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
         end else begin
            uq  = ua / ub;
            ur  = ua % ub;
            res = {ur[31:0], uq[31:0]};
         end
         return {1'b0, res};
      end
      prod = sgn ? 64'(sa * sb) : 64'(ua * ub);
      res  = prod;
`ifdef MULDIV_ACC_EN
      if (op[2]) res = op[1] ? (hilo - prod) : (hilo + prod);
`endif
      return {1'b0, res};
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
      if (op == 3'd2 || op == 3'd3) return (b == 32'd0) ? 1 : WIDTH + 2;
      return MUL_CYCLES;
   endfunction

   // Called half a cycle clear of the edge; returns in the done_o cycle so a
   // following call exercises back-to-back acceptance.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo, input bit poke, output logic [63:0] got);
      logic [64:0] exp;
      int          lat, k;
      exp = ref_model(op, a, b, hilo);
      lat = ref_latency(op, b);
      start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; hilo_i = hilo;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      op_i = 3'($urandom); operand_a_i = $urandom; operand_b_i = $urandom;
      hilo_i = {$urandom, $urandom};
      check_val("busy_after_accept", 64'(busy_o), 64'd1);
      check_val("result_held", result_o, last_res);
      k = 0;
      while (k < lat + 8) begin
         if (poke && k == 2) start_i = 1'b1;
         @(posedge clock_i); #1;
         start_i = 1'b0;
         k++;
         if (done_o) break;
      end
      check_val("latency", 64'(k), 64'(lat));
      check_val("result", result_o, exp[63:0]);
      check_val("div_by_zero", 64'(div_by_zero_o), 64'(exp[64]));
      check_val("busy_at_done", 64'(busy_o), 64'd0);
      got      = result_o;
      last_res = exp[63:0];
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock_i); #1;
         if (done_o) n++;
      end
   endtask

   function automatic logic [31:0] pick_operand(input bit allow_zero);
      case ($urandom_range(0, 7))
         0: return allow_zero ? 32'd0 : 32'd1;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [63:0] got;
      logic [2:0]  rop;
      int          n;
      reset_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
      operand_a_i = '0; operand_b_i = '0; hilo_i = '0;
      #1;
      check_val("reset_busy", 64'(busy_o), 64'd0);
      check_val("reset_done", 64'(done_o), 64'd0);
      check_val("reset_result", result_o, 64'd0);
      check_val("reset_dbz", 64'(div_by_zero_o), 64'd0);
      #20;
      @(negedge clock_i); reset_i = 1'b1;
      @(posedge clock_i); #1;

      run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 64'd0, 1'b0, got);
      check_val("tp_mult", got, 64'hFFFF_FFFF_FFFF_FFFA);
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0, got);
      check_val("tp_div_neg", got, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(3'd3, 32'd7, 32'd2, 64'd0, 1'b0, got);
      check_val("tp_divu", got, {32'd1, 32'd3});
      run_op(3'd3, 32'h1234, 32'd0, 64'd0, 1'b0, got);
      check_val("tp_div_zero", got, {32'h0000_1234, 32'hFFFF_FFFF});
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b0, got);
      check_val("tp_div_ovf", got, {32'd0, 32'h8000_0000});
      run_op(3'd6, 32'd3, 32'd5, 64'h10, 1'b0, got);
`ifdef MULDIV_ACC_EN
      check_val("tp_msub", got, 64'd1);
`else
      check_val("tp_msub_as_mult", got, 64'd15);
`endif
      run_op(3'd2, 32'd1000, 32'hFFFF_FFFD, 64'd0, 1'b1, got);

      // flush sampled at the tenth edge after a DIV is accepted
      start_i = 1'b1; op_i = 3'd2; operand_a_i = $urandom; operand_b_i = 32'd9;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      repeat (9) begin @(posedge clock_i); #1; end
      flush_i = 1'b1;
      @(posedge clock_i); #1;
      flush_i = 1'b0;
      check_val("flush_busy", 64'(busy_o), 64'd0);
      check_val("flush_done", 64'(done_o), 64'd0);
      check_val("flush_result", result_o, last_res);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0, got);
      count_done(40, n);
      check_val("flush_no_late_done", 64'(n), 64'd0);

      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd2; operand_a_i = 32'd50; operand_b_i = 32'd5;
      @(posedge clock_i); #1;
      start_i = 1'b0; flush_i = 1'b0;
      check_val("flush_start_busy", 64'(busy_o), 64'd0);
      count_done(40, n);
      check_val("flush_start_no_done", 64'(n), 64'd0);

      for (int i = 0; i < 80; i++) begin
         rop = 3'($urandom_range(0, 7));
         run_op(rop, pick_operand(1'b1), pick_operand($urandom_range(0, 3) == 0),
                {$urandom, $urandom}, 1'b0, got);
      end

      // asynchronous reset in the middle of a divide
      start_i = 1'b1; op_i = 3'd3; operand_a_i = $urandom; operand_b_i = 32'd3;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      repeat (5) begin @(posedge clock_i); #1; end
      #2 reset_i = 1'b0;
      #1;
      check_val("mid_reset_busy", 64'(busy_o), 64'd0);
      check_val("mid_reset_done", 64'(done_o), 64'd0);
      check_val("mid_reset_result", result_o, 64'd0);
      check_val("mid_reset_dbz", 64'(div_by_zero_o), 64'd0);
      @(posedge clock_i); #1;
      reset_i  = 1'b1;
      last_res = '0;
      count_done(40, n);
      check_val("mid_reset_no_done", 64'(n), 64'd0);
      run_op(3'd3, 32'd100, 32'd7, 64'd0, 1'b0, got);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
